regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Next-generation RISC-V integer register file for the pipelined core.
- NUM_READ combinational read ports, one synchronous write port, architectural x0 hardwired to zero, and a write-to-read bypass.
- Per-register pending-write counters (scoreboard) so decode can detect RAW hazards and stall.
- Sits between decode (read and issue) and writeback (write and retire); a0 is exported for the testbench/display.

Parameters:
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_READ, 2, number of read ports (1..4).
- PEND_WIDTH, 2, width of each pending-write counter; max in-flight writes per register = 2**PEND_WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- WE3  in  1  writeback enable.
- A3  in  ADDRESS_WIDTH  writeback destination index.
- WD3  in  DATA_WIDTH  writeback data.
- RA  in  NUM_READ*ADDRESS_WIDTH  read indices; port i = RA[i*AW +: AW].
- RD  out  NUM_READ*DATA_WIDTH  read data, packed the same way as RA.
- RBUSY  out  NUM_READ  port i source has a pending write not yet visible.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  ADDRESS_WIDTH  destination of the issued instruction.
- issue_ready  out  1  issue is accepted this cycle.
- a0  out  DATA_WIDTH  contents of x10.

Behaviour:
- Reset (async assert, sync-safe deassert): all registers clear to 0 and all pending counters clear to 0. Immediately after reset, every RD = 0, RBUSY = 0, issue_ready = 1, a0 = 0. Reset mid-operation discards all in-flight writes.
- Write:
  - On posedge, if WE3 and A3 != 0, then reg[A3] <= WD3.
  - Writes to x0 are dropped, and x0 always reads 0.
- Read:
  - Combinational, zero latency.
  - RD[i] = 0 if RA[i] == 0; else WD3 if WE3 && A3 == RA[i] (same-cycle bypass); else reg[RA[i]].
- Scoreboard:
  - An issue fires when issue_valid && issue_ready && issue_rd != 0. A retire fires when WE3 && A3 != 0.
  - Counter pend[r], evaluated at posedge:
    - issue only to r: +1.
    - retire only to r: -1.
    - issue and retire to the same r in the same cycle: unchanged.
  - Retire to a register whose counter is 0: counter stays 0 (no underflow); the write is still performed.
  - issue_ready = 0 when issue_rd != 0 and pend[issue_rd] == max and there is no same-cycle retire to issue_rd. Otherwise 1. issue_rd = 0 is always ready.
  - issue_ready depends combinationally on issue_rd, A3 and WE3 only, not on issue_valid.
- RBUSY[i]:
  - 1 iff RA[i] != 0 and pend[RA[i]] > 0, except that it is 0 when pend[RA[i]] == 1 and a same-cycle retire to RA[i] is bypassing.
  - RBUSY reflects the pre-edge state; it does not include a same-cycle issue.
- a0 = reg[10], registered value with no bypass.
- All outputs are purely combinational from state plus the inputs listed above; there are no combinational paths from issue_valid.

Decomposition:
- Package regfile_pkg:
  - constants XLEN=32 and REG_AW=5;
  - typedef reg_idx_t (logic [REG_AW-1:0]) and xword_t;
  - localparams A0_IDX=10 and ZERO_IDX=0.
- One natural sub-module, pend_counter: a single saturating up/down counter with inc, dec and at_max outputs, instantiated 2**ADDRESS_WIDTH times in a generate loop.
- Read ports are generated in a generate loop over NUM_READ.

Test Plan:
1. Reset then read: rst_n low for 2 cycles with WE3=1, A3=5, WD3=0xDEAD; release and read RA0=5 -> RD0=0, RBUSY=0, a0=0.
2. Write and bypass: WE3=1, A3=10, WD3=0x1234, RA0=10 in the same cycle -> RD0=0x1234 combinationally and a0 still 0. Next cycle a0=0x1234.
3. x0 protection: WE3=1, A3=0, WD3=0xFFFFFFFF and issue_rd=0 issued -> RD for RA=0 stays 0, no counter changes, issue_ready=1.
4. RAW hazard: issue rd=7 -> next cycle RA1=7 gives RBUSY[1]=1. Writeback A3=7, WD3=0x55 with RA1=7 -> RBUSY[1]=0 and RD1=0x55 in that cycle.
5. Saturation (PEND_WIDTH=2): issue rd=3 three times -> issue_ready=0 for issue_rd=3. Add a same-cycle retire A3=3 -> issue_ready=1, and the counter stays at 3.
6. Simultaneous events: pend[4]=1; issue rd=4 and retire A3=4 in the same cycle -> pend[4] stays 1, RBUSY=1 next cycle. Then assert rst_n low mid-sequence -> all RBUSY=0 and all registers 0 asynchronously.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;

  localparam int unsigned A0_IDX   = 10;
  localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
module pend_counter #(
  parameter int unsigned PEND_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  dec_i,
  output logic [PEND_WIDTH-1:0] cnt_o,
  output logic                  at_max_o
);

  logic [PEND_WIDTH-1:0] cnt_q, cnt_d;

  assign at_max_o = &cnt_q;
  assign cnt_o    = cnt_q;

  // Simultaneous inc and dec cancel; both ends clamp.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 hardwired to zero, write-to-read bypass and
// per-register pending-write counters for RAW hazard detection at decode.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = REG_AW,
  parameter int unsigned DATA_WIDTH    = XLEN,
  parameter int unsigned NUM_READ      = 2,
  parameter int unsigned PEND_WIDTH    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              WE3,
  input  logic [ADDRESS_WIDTH-1:0]          A3,
  input  logic [DATA_WIDTH-1:0]             WD3,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] RA,
  output logic [NUM_READ*DATA_WIDTH-1:0]    RD,
  output logic [NUM_READ-1:0]               RBUSY,
  input  logic                              issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]          issue_rd,
  output logic                              issue_ready,
  output logic [DATA_WIDTH-1:0]             a0
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(ZERO_IDX);
  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR   = ADDRESS_WIDTH'(A0_IDX);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [PEND_WIDTH-1:0] pend   [DEPTH];
  logic [DEPTH-1:0]      at_max;

  logic retire;
  logic issue_fire;

  assign retire     = WE3 && (A3 != ZERO_ADDR);
  // A full counter still accepts an issue when a retire to it lands this cycle.
  assign issue_ready = !((issue_rd != ZERO_ADDR) && at_max[issue_rd] &&
                         !(retire && (A3 == issue_rd)));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (retire) begin
      regs_q[A3] <= WD3;
    end
  end

  assign a0 = regs_q[A0_ADDR];

  for (genvar r = 0; r < DEPTH; r++) begin : g_pend
    pend_counter #(
      .PEND_WIDTH(PEND_WIDTH)
    ) u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (issue_fire && (issue_rd == ADDRESS_WIDTH'(r))),
      .dec_i    (retire && (A3 == ADDRESS_WIDTH'(r))),
      .cnt_o    (pend[r]),
      .at_max_o (at_max[r])
    );
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] ra;
    logic                     byp;

    assign ra  = RA[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign byp = retire && (A3 == ra);

    assign RD[i*DATA_WIDTH +: DATA_WIDTH] = (ra == ZERO_ADDR) ? '0  :
                                            byp               ? WD3 :
                                                                regs_q[ra];

    // The last outstanding write landing this cycle is already visible via bypass.
    assign RBUSY[i] = (ra != ZERO_ADDR) && (pend[ra] != '0) &&
                      !((pend[ra] == PEND_WIDTH'(1)) && byp);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic [1:0]  RBUSY;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [31:0] a0;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WE3         (WE3),
    .A3          (A3),
    .WD3         (WD3),
    .RA          (RA),
    .RD          (RD),
    .RBUSY       (RBUSY),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .a0          (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEAD;
    RA = '0; issue_valid = 1'b0; issue_rd = '0;
    edge_step();
    edge_step();

    // 1: reset drops the write in flight
    rst_n = 1'b1; WE3 = 1'b0; RA[4:0] = 5'd5; #1;
    chk("rst_rd0", RD[31:0], 32'h0);
    chk("rst_rbusy", {30'd0, RBUSY}, 32'h0);
    chk("rst_a0", a0, 32'h0);
    chk("rst_ready", {31'd0, issue_ready}, 32'h1);

    // 2: bypass to a0 register, a0 itself is registered
    WE3 = 1'b1; A3 = 5'd10; WD3 = 32'h1234; RA[4:0] = 5'd10; #1;
    chk("byp_rd0", RD[31:0], 32'h1234);
    chk("byp_a0_old", a0, 32'h0);
    edge_step();
    WE3 = 1'b0; #1;
    chk("wr_a0", a0, 32'h1234);
    chk("wr_rd0", RD[31:0], 32'h1234);
    chk("wr_rbusy0", {31'd0, RBUSY[0]}, 32'h0);

    // 3: x0 protection
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF; RA = '0;
    issue_valid = 1'b1; issue_rd = 5'd0; #1;
    chk("x0_byp_rd0", RD[31:0], 32'h0);
    chk("x0_ready", {31'd0, issue_ready}, 32'h1);
    edge_step();
    WE3 = 1'b0; issue_valid = 1'b0; RA[9:5] = 5'd10; #1;
    chk("x0_rd0", RD[31:0], 32'h0);
    chk("x0_rbusy", {30'd0, RBUSY}, 32'h0);
    chk("x0_rd1_x10", RD[63:32], 32'h1234);

    // 4: RAW hazard on x7
    issue_valid = 1'b1; issue_rd = 5'd7; RA[9:5] = 5'd7; #1;
    chk("raw_ready", {31'd0, issue_ready}, 32'h1);
    chk("raw_pre_rbusy1", {31'd0, RBUSY[1]}, 32'h0);
    edge_step();
    issue_valid = 1'b0; #1;
    chk("raw_rbusy1", {31'd0, RBUSY[1]}, 32'h1);
    chk("raw_rd1_old", RD[63:32], 32'h0);
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h55; #1;
    chk("raw_wb_rbusy1", {31'd0, RBUSY[1]}, 32'h0);
    chk("raw_wb_rd1", RD[63:32], 32'h55);
    edge_step();
    WE3 = 1'b0; #1;
    chk("raw_post_rbusy1", {31'd0, RBUSY[1]}, 32'h0);
    chk("raw_post_rd1", RD[63:32], 32'h55);

    // 5: saturation on x3
    issue_valid = 1'b1; issue_rd = 5'd3; RA[4:0] = 5'd3; #1;
    chk("sat_ready0", {31'd0, issue_ready}, 32'h1);
    edge_step();
    chk("sat_ready1", {31'd0, issue_ready}, 32'h1);
    edge_step();
    chk("sat_ready2", {31'd0, issue_ready}, 32'h1);
    edge_step();
    chk("sat_full_ready", {31'd0, issue_ready}, 32'h0);
    chk("sat_rbusy0", {31'd0, RBUSY[0]}, 32'h1);
    edge_step();
    chk("sat_hold_ready", {31'd0, issue_ready}, 32'h0);
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h33; #1;
    chk("sat_retire_ready", {31'd0, issue_ready}, 32'h1);
    chk("sat_retire_rbusy0", {31'd0, RBUSY[0]}, 32'h1);
    edge_step();
    WE3 = 1'b0; #1;
    chk("sat_still_full", {31'd0, issue_ready}, 32'h0);
    issue_valid = 1'b0; WE3 = 1'b1; A3 = 5'd3; #1;
    edge_step();
    chk("drain2_rbusy0", {31'd0, RBUSY[0]}, 32'h1);
    edge_step();
    chk("drain1_rbusy0", {31'd0, RBUSY[0]}, 32'h0);
    edge_step();
    WE3 = 1'b0; #1;
    chk("drain0_rbusy0", {31'd0, RBUSY[0]}, 32'h0);
    chk("drain0_rd0", RD[31:0], 32'h33);
    chk("drain0_ready", {31'd0, issue_ready}, 32'h1);

    // retire with no pending write must not wrap the counter
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h99; edge_step();
    WE3 = 1'b0; RA[9:5] = 5'd9; #1;
    chk("uflow_rbusy1", {31'd0, RBUSY[1]}, 32'h0);
    chk("uflow_rd1", RD[63:32], 32'h99);

    // 6: simultaneous issue and retire on x4, then async reset
    issue_valid = 1'b1; issue_rd = 5'd4; edge_step();
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h44; edge_step();
    WE3 = 1'b0; issue_valid = 1'b0; RA[4:0] = 5'd4; RA[9:5] = 5'd7; #1;
    chk("sim_rbusy0", {31'd0, RBUSY[0]}, 32'h1);
    chk("sim_rd0", RD[31:0], 32'h44);
    chk("sim_rd1", RD[63:32], 32'h55);
    rst_n = 1'b0; #1;
    chk("arst_rbusy", {30'd0, RBUSY}, 32'h0);
    chk("arst_rd0", RD[31:0], 32'h0);
    chk("arst_rd1", RD[63:32], 32'h0);
    chk("arst_a0", a0, 32'h0);
    #2;
    rst_n = 1'b1; issue_rd = 5'd3; #1;
    chk("arst_ready", {31'd0, issue_ready}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
